// File: rtl/pc_sequencer_if.sv
// Control/datapath-facing signal bundle of the fetch/execute sequencer.
// The master side drives enable, control and data inputs; the slave side is the sequencer.
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 en;
    logic [1:0]           PS;
    logic                 IL;
    logic [15:0]          instr_in;
    logic [PC_WIDTH-1:0]  bus_a;
    logic                 state;
    logic [PC_WIDTH-1:0]  pc;
    logic [15:0]          ir;
    logic [3:0]           opcode;
    logic [3:0]           DR;
    logic [3:0]           SA;
    logic [3:0]           SB;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        output en, PS, IL, instr_in, bus_a,
        input  state, pc, ir, opcode, DR, SA, SB, retired
    );

    modport slave (
        input  en, PS, IL, instr_in, bus_a,
        output state, pc, ir, opcode, DR, SA, SB, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: phase bit, program counter, instruction register
// and a saturating count of retired instructions.
module pc_sequencer #(
    parameter int unsigned         PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned         CNT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } phase_t;

    phase_t               st_q, st_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]          ir_q, ir_d;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;
    logic [7:0]           br_off;
    logic [PC_WIDTH-1:0]  br_ext;

    // Branch offset is {DR,SB}, sign-extended through a signed cast.
    assign br_off = {ir_q[11:8], ir_q[3:0]};
    assign br_ext = PC_WIDTH'($signed(br_off));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= FETCH;
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            ret_q <= '0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            ret_q <= ret_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        ret_d = ret_q;
        if (bus.en) begin
            unique case (st_q)
                FETCH: begin
                    st_d = EXECUTE;
                    if (bus.IL) ir_d = bus.instr_in;
                end
                EXECUTE: begin
                    st_d = FETCH;
                    unique case (bus.PS)
                        2'b00: pc_d = pc_q;
                        2'b01: pc_d = pc_q + PC_WIDTH'(1);
                        2'b10: pc_d = pc_q + br_ext;
                        2'b11: pc_d = bus.bus_a;
                        default: pc_d = pc_q;
                    endcase
                    if (ret_q != '1) ret_d = ret_q + CNT_WIDTH'(1);
                end
                default: st_d = FETCH;
            endcase
        end
    end

    assign bus.state   = (st_q == EXECUTE);
    assign bus.pc      = pc_q;
    assign bus.ir      = ir_q;
    assign bus.opcode  = ir_q[15:12];
    assign bus.DR      = ir_q[11:8];
    assign bus.SA      = ir_q[7:4];
    assign bus.SB      = ir_q[3:0];
    assign bus.retired = ret_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, fetch/increment, branch, jump,
// enable hold, mid-instruction reset and counter saturation on a narrow instance.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_WIDTH(8), .CNT_WIDTH(16)) sif0 ();
    pc_sequencer_if #(.PC_WIDTH(8), .CNT_WIDTH(4))  sif1 ();

    pc_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif0.slave)
    );

    pc_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(4)) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (sif1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [7:0] pc,
                           input logic [15:0] ir, input logic [15:0] ret);
        chk({tag, ".state"},   32'(sif0.state),   32'(st));
        chk({tag, ".pc"},      32'(sif0.pc),      32'(pc));
        chk({tag, ".ir"},      32'(sif0.ir),      32'(ir));
        chk({tag, ".retired"}, 32'(sif0.retired), 32'(ret));
    endtask

    initial begin
        rst_n = 1'b0;
        rst1_n = 1'b0;
        sif0.en = 1'b0; sif0.PS = 2'b00; sif0.IL = 1'b0;
        sif0.instr_in = 16'h0000; sif0.bus_a = 8'h00;
        sif1.en = 1'b1; sif1.PS = 2'b01; sif1.IL = 1'b0;
        sif1.instr_in = 16'h0000; sif1.bus_a = 8'h00;

        tick();
        tick();
        chk_all("reset", 1'b0, 8'h00, 16'h0000, 16'd0);
        chk("reset.opcode", 32'(sif0.opcode), 32'h0);
        rst_n = 1'b1;

        // Fetch with IL, then execute increment
        sif0.en = 1'b1; sif0.IL = 1'b1; sif0.instr_in = 16'h1234; sif0.PS = 2'b01;
        tick();
        chk_all("fetch1", 1'b1, 8'h00, 16'h1234, 16'd0);
        chk("fetch1.opcode", 32'(sif0.opcode), 32'h1);
        chk("fetch1.DR", 32'(sif0.DR), 32'h2);
        chk("fetch1.SA", 32'(sif0.SA), 32'h3);
        chk("fetch1.SB", 32'(sif0.SB), 32'h4);
        sif0.IL = 1'b0;
        tick();
        chk_all("inc1", 1'b0, 8'h01, 16'h1234, 16'd1);

        // Jump during fetch is ignored, during execute it loads bus_a
        sif0.PS = 2'b11; sif0.bus_a = 8'hA5;
        tick();
        chk_all("jmpfetch", 1'b1, 8'h01, 16'h1234, 16'd1);
        tick();
        chk_all("jmpexec", 1'b0, 8'hA5, 16'h1234, 16'd2);

        // Jump to 0x10, then branch back by 2
        sif0.bus_a = 8'h10;
        tick();
        tick();
        chk_all("jmp10", 1'b0, 8'h10, 16'h1234, 16'd3);
        sif0.IL = 1'b1; sif0.instr_in = 16'hBF0E; sif0.PS = 2'b10;
        tick();
        chk_all("brfetch", 1'b1, 8'h10, 16'hBF0E, 16'd3);
        sif0.instr_in = 16'hFFFF;
        tick();
        chk_all("brneg", 1'b0, 8'h0E, 16'hBF0E, 16'd4);

        // Jump to 0xFF, then branch +5 wraps to 0x04
        sif0.IL = 1'b0; sif0.PS = 2'b11; sif0.bus_a = 8'hFF;
        tick();
        tick();
        chk_all("jmpff", 1'b0, 8'hFF, 16'hBF0E, 16'd5);
        sif0.IL = 1'b1; sif0.instr_in = 16'h0005; sif0.PS = 2'b10;
        tick();
        sif0.IL = 1'b0;
        tick();
        chk_all("brwrap", 1'b0, 8'h04, 16'h0005, 16'd6);

        // Enable low freezes everything regardless of PS/IL
        sif0.en = 1'b0; sif0.IL = 1'b1; sif0.PS = 2'b01;
        for (int i = 0; i < 3; i++) begin
            sif0.instr_in = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            tick();
        end
        chk_all("hold", 1'b0, 8'h04, 16'h0005, 16'd6);
        sif0.en = 1'b1; sif0.instr_in = 16'h1234;
        tick();
        chk_all("resume_f", 1'b1, 8'h04, 16'h1234, 16'd6);
        sif0.IL = 1'b0;
        tick();
        chk_all("resume_x", 1'b0, 8'h05, 16'h1234, 16'd7);

        // Asynchronous reset between edges, mid-instruction
        sif0.IL = 1'b1; sif0.instr_in = 16'h2345;
        tick();
        chk_all("preRst", 1'b1, 8'h05, 16'h2345, 16'd7);
        #2 rst_n = 1'b0;
        #1;
        chk_all("asyncRst", 1'b0, 8'h00, 16'h0000, 16'd0);
        chk("asyncRst.DR", 32'(sif0.DR), 32'h0);
        tick();
        tick();
        chk_all("rstHold", 1'b0, 8'h00, 16'h0000, 16'd0);
        rst_n = 1'b1; sif0.IL = 1'b0; sif0.PS = 2'b11; sif0.bus_a = 8'h33;
        tick();
        chk_all("postRst", 1'b1, 8'h00, 16'h0000, 16'd0);

        // Narrow counter saturates at 4'hF; pc keeps incrementing
        rst1_n = 1'b1;
        for (int i = 0; i < 28; i++) tick();
        chk("sat14.retired", 32'(sif1.retired), 32'hE);
        tick();
        tick();
        chk("sat15.retired", 32'(sif1.retired), 32'hF);
        for (int i = 0; i < 10; i++) tick();
        chk("sat20.retired", 32'(sif1.retired), 32'hF);
        chk("sat20.pc", 32'(sif1.pc), 32'h14);
        chk("sat20.state", 32'(sif1.state), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
